// File: rtl/thiele_solver_arbiter.sv
// Round-robin arbiter that time-shares one thiele_graph_solver among several clients,
// drives the solver's start/done handshake, and guards each solve with a watchdog.
module thiele_solver_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int NODES          = 9,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STAT_W         = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CLIENTS-1:0]         req,
    output logic [NUM_CLIENTS-1:0]         grant,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [$clog2(NUM_CLIENTS)-1:0] resp_client,
    output logic                           resp_success,
    output logic                           resp_timeout,
    output logic [2*NODES-1:0]             resp_colouring,
    output logic [31:0]                    resp_mu_total,
    output logic                           solver_start,
    output logic                           solver_abort,
    input  logic                           solver_done,
    input  logic                           solver_success,
    input  logic [2*NODES-1:0]             solver_colouring,
    input  logic [31:0]                    solver_mu_total,
    output logic [STAT_W-1:0]              jobs_done,
    output logic [STAT_W-1:0]              jobs_timeout
);

    localparam int IDW = $clog2(NUM_CLIENTS);
    localparam int CW  = 2 * NODES;
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0]    ID_LAST    = IDW'(NUM_CLIENTS - 1);
    localparam logic [STAT_W-1:0] STAT_MAX   = {STAT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_ABORT,
        S_RELEASE,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [IDW-1:0]         cur_id_q, cur_id_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic                   start_q, start_d;
    logic                   abort_q, abort_d;
    logic                   abort_cnt_q, abort_cnt_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   res_success_q, res_success_d;
    logic                   res_timeout_q, res_timeout_d;
    logic [CW-1:0]          res_col_q, res_col_d;
    logic [31:0]            res_mu_q, res_mu_d;
    logic [STAT_W-1:0]      jobs_done_q, jobs_done_d;
    logic [STAT_W-1:0]      jobs_timeout_q, jobs_timeout_d;

    logic                   found;
    logic [IDW-1:0]         winner;
    int                     idx;

    // Scan clients starting at the pointer, wrapping, and take the first requester.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CLIENTS) begin
                idx = idx - NUM_CLIENTS;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cur_id_d       = cur_id_q;
        timer_d        = timer_q;
        grant_d        = '0;
        start_d        = start_q;
        abort_d        = abort_q;
        abort_cnt_d    = abort_cnt_q;
        resp_valid_d   = resp_valid_q;
        res_success_d  = res_success_q;
        res_timeout_d  = res_timeout_q;
        res_col_d      = res_col_q;
        res_mu_d       = res_mu_q;
        jobs_done_d    = jobs_done_q;
        jobs_timeout_d = jobs_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d[winner] = 1'b1;
                    start_d         = 1'b1;
                    cur_id_d        = winner;
                    timer_d         = '0;
                    ptr_d           = (winner == ID_LAST) ? '0 : winner + 1'b1;
                    state_d         = S_RUN;
                end
            end
            S_RUN: begin
                timer_d = timer_q + 1'b1;
                // A done seen on the watchdog's last cycle still counts as a normal finish.
                if (solver_done) begin
                    start_d       = 1'b0;
                    res_success_d = solver_success;
                    res_timeout_d = 1'b0;
                    res_col_d     = solver_colouring;
                    res_mu_d      = solver_mu_total;
                    if (jobs_done_q != STAT_MAX) begin
                        jobs_done_d = jobs_done_q + 1'b1;
                    end
                    state_d = S_RELEASE;
                end else if (timer_q == TIMER_LAST) begin
                    start_d     = 1'b0;
                    abort_d     = 1'b1;
                    abort_cnt_d = 1'b0;
                    state_d     = S_ABORT;
                end
            end
            S_ABORT: begin
                if (!abort_cnt_q) begin
                    abort_cnt_d = 1'b1;
                end else begin
                    abort_d       = 1'b0;
                    res_success_d = 1'b0;
                    res_timeout_d = 1'b1;
                    res_col_d     = '0;
                    res_mu_d      = '0;
                    if (jobs_timeout_q != STAT_MAX) begin
                        jobs_timeout_d = jobs_timeout_q + 1'b1;
                    end
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RELEASE: begin
                if (!solver_done) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            cur_id_q       <= '0;
            timer_q        <= '0;
            grant_q        <= '0;
            start_q        <= 1'b0;
            abort_q        <= 1'b0;
            abort_cnt_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            res_success_q  <= 1'b0;
            res_timeout_q  <= 1'b0;
            res_col_q      <= '0;
            res_mu_q       <= '0;
            jobs_done_q    <= '0;
            jobs_timeout_q <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cur_id_q       <= cur_id_d;
            timer_q        <= timer_d;
            grant_q        <= grant_d;
            start_q        <= start_d;
            abort_q        <= abort_d;
            abort_cnt_q    <= abort_cnt_d;
            resp_valid_q   <= resp_valid_d;
            res_success_q  <= res_success_d;
            res_timeout_q  <= res_timeout_d;
            res_col_q      <= res_col_d;
            res_mu_q       <= res_mu_d;
            jobs_done_q    <= jobs_done_d;
            jobs_timeout_q <= jobs_timeout_d;
        end
    end

    assign grant          = grant_q;
    assign solver_start   = start_q;
    assign solver_abort   = abort_q;
    assign resp_valid     = resp_valid_q;
    assign resp_client    = cur_id_q;
    assign resp_success   = res_success_q;
    assign resp_timeout   = res_timeout_q;
    assign resp_colouring = res_col_q;
    assign resp_mu_total  = res_mu_q;
    assign jobs_done      = jobs_done_q;
    assign jobs_timeout   = jobs_timeout_q;

endmodule

// File: tb/tb_thiele_solver_arbiter.sv
// Bench for thiele_solver_arbiter: stub solver, scoreboard of expected responses,
// round-robin order, watchdog abort, backpressure, done/timeout tie and mid-job reset.
module tb_thiele_solver_arbiter;

    localparam int NC  = 4;
    localparam int ND  = 9;
    localparam int TO  = 16;
    localparam int SW  = 3;
    localparam int SAT = 7;

    logic          clk;
    logic          reset;
    logic [NC-1:0] req;
    logic [NC-1:0] grant;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_client;
    logic          resp_success;
    logic          resp_timeout;
    logic [2*ND-1:0] resp_colouring;
    logic [31:0]   resp_mu_total;
    logic          solver_start;
    logic          solver_abort;
    logic          solver_done;
    logic          solver_success;
    logic [2*ND-1:0] solver_colouring;
    logic [31:0]   solver_mu_total;
    logic [SW-1:0] jobs_done;
    logic [SW-1:0] jobs_timeout;

    thiele_solver_arbiter #(
        .NUM_CLIENTS(NC), .NODES(ND), .TIMEOUT_CYCLES(TO), .STAT_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_client(resp_client),
        .resp_success(resp_success), .resp_timeout(resp_timeout),
        .resp_colouring(resp_colouring), .resp_mu_total(resp_mu_total),
        .solver_start(solver_start), .solver_abort(solver_abort),
        .solver_done(solver_done), .solver_success(solver_success),
        .solver_colouring(solver_colouring), .solver_mu_total(solver_mu_total),
        .jobs_done(jobs_done), .jobs_timeout(jobs_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stub solver: done rises stub_delay start-cycles after start, falls 2 cycles after start drops.
    logic        stub_hang;
    int          stub_delay;
    logic        stub_succ;
    logic [17:0] stub_col;
    logic [31:0] stub_mu;
    int          scnt;
    int          fcnt;

    assign solver_success   = stub_succ;
    assign solver_colouring = stub_col;
    assign solver_mu_total  = stub_mu;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            solver_done <= 1'b0;
            scnt        <= 0;
            fcnt        <= 0;
        end else if (solver_abort) begin
            solver_done <= 1'b0;
            scnt        <= 0;
            fcnt        <= 0;
        end else if (solver_start) begin
            scnt <= scnt + 1;
            fcnt <= 0;
            if (!stub_hang && (scnt + 1 >= stub_delay)) solver_done <= 1'b1;
        end else if (solver_done) begin
            if (fcnt == 1) begin
                solver_done <= 1'b0;
                fcnt        <= 0;
            end else begin
                fcnt <= fcnt + 1;
            end
        end else begin
            scnt <= 0;
        end
    end

    typedef struct {
        logic [1:0]  id;
        logic        succ;
        logic        to;
        logic [17:0] col;
        logic [31:0] mu;
    } exp_t;

    exp_t sb[$];
    int   rd_ptr = 0;
    int   exp_done = 0;
    int   exp_to = 0;
    int   start_cycles = 0;
    int   abort_cycles = 0;
    int   valid_cycles = 0;

    // Monitor: pops the scoreboard on each accepted response and tracks the job counters.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_done = 0;
                exp_to   = 0;
            end else begin
                if (solver_start) start_cycles++;
                if (solver_abort) abort_cycles++;
                if (resp_valid) valid_cycles++;
                if (resp_valid && resp_ready) begin
                    chk("resp_expected", (rd_ptr < sb.size()), 1'b1);
                    if (rd_ptr < sb.size()) begin
                        e = sb[rd_ptr];
                        rd_ptr++;
                        if (e.to) exp_to = (exp_to == SAT) ? SAT : exp_to + 1;
                        else      exp_done = (exp_done == SAT) ? SAT : exp_done + 1;
                        chk("resp_client", resp_client, e.id);
                        chk("resp_success", resp_success, e.succ);
                        chk("resp_timeout", resp_timeout, e.to);
                        chk("resp_colouring", resp_colouring, e.col);
                        chk("resp_mu", resp_mu_total, e.mu);
                        chk("jobs_done", jobs_done, exp_done);
                        chk("jobs_timeout", jobs_timeout, exp_to);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (grant == '0 && n < 100);
    endtask

    task automatic push_exp(input logic [1:0] id, input logic hang);
        exp_t e;
        e.id   = id;
        e.succ = hang ? 1'b0 : stub_succ;
        e.to   = hang;
        e.col  = hang ? '0 : stub_col;
        e.mu   = hang ? '0 : stub_mu;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (rd_ptr < sb.size() && n < 300) begin
            cyc();
            n++;
        end
        chk("drain", rd_ptr, sb.size());
    endtask

    task automatic set_stub(input logic hang, input int delay, input logic succ,
                            input logic [17:0] col, input logic [31:0] mu);
        stub_hang  = hang;
        stub_delay = delay;
        stub_succ  = succ;
        stub_col   = col;
        stub_mu    = mu;
    endtask

    task automatic run_job(input logic [NC-1:0] reqv, input logic [NC-1:0] exp_grant,
                           input logic [NC-1:0] req_after, input logic [1:0] id,
                           input logic hang);
        int n;
        req = reqv;
        wait_grant(n);
        chk("grant", grant, exp_grant);
        req = req_after;
        push_exp(id, hang);
        drain();
    endtask

    initial begin
        int n;
        int s0;
        int a0;
        int v0;
        #1_000_000;
        $display("FAIL global_timeout observed %0d expected 0", 1);
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int s0;
        int a0;
        int v0;
        logic [NC-1:0] order [4];
        reset      = 1'b1;
        req        = '0;
        resp_ready = 1'b1;
        set_stub(1'b0, 10, 1'b1, 18'h0, 32'h00C0_0000);
        repeat (3) cyc();
        chk("rst_grant", grant, 0);
        chk("rst_start", solver_start, 0);
        chk("rst_abort", solver_abort, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_mu", resp_mu_total, 0);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_jobs_timeout", jobs_timeout, 0);
        reset = 1'b0;
        cyc();

        // Single client, basic solve.
        set_stub(1'b0, 10, 1'b1, 18'h2D5A5, 32'h00C0_0000);
        run_job(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0);
        // Highest client alone so the pointer wraps back to 0.
        set_stub(1'b0, 3, 1'b0, 18'h15555, 32'h1234_5678);
        run_job(4'b1000, 4'b1000, 4'b0000, 2'd3, 1'b0);

        // All clients requesting: strict rotation.
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000;
        for (int j = 0; j < 4; j++) begin
            set_stub(1'b0, 2 + j, j[0], 18'(j * 18'h1111 + 1), 32'h0001_0000 * (j + 1));
            run_job(4'b1111, order[j], (j == 3) ? 4'b0000 : 4'b1111, 2'(j), 1'b0);
        end

        // Watchdog abort.
        set_stub(1'b1, 10, 1'b1, 18'h3FFFF, 32'hDEAD_BEEF);
        s0 = start_cycles;
        a0 = abort_cycles;
        run_job(4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1);
        chk("abort_start_cycles", start_cycles - s0, TO);
        chk("abort_cycles", abort_cycles - a0, 2);

        // Backpressure with another client waiting.
        set_stub(1'b0, 5, 1'b1, 18'h0F0F0, 32'hCAFE_0001);
        resp_ready = 1'b0;
        req = 4'b0010;
        wait_grant(n);
        chk("bp_grant", grant, 4'b0010);
        req = 4'b0001;
        push_exp(2'd1, 1'b0);
        n = 0;
        while (!resp_valid && n < 100) begin
            cyc();
            n++;
        end
        chk("bp_valid_wait", resp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_valid_held", resp_valid, 1);
            chk("bp_mu_held", resp_mu_total, 32'hCAFE_0001);
            chk("bp_client_held", resp_client, 1);
            chk("bp_no_grant", grant, 0);
        end
        resp_ready = 1'b1;
        wait_grant(n);
        chk("bp_grant_latency", n, 2);
        chk("bp_next_grant", grant, 4'b0001);
        req = 4'b0000;
        push_exp(2'd0, 1'b0);
        drain();

        // Done on the watchdog's last cycle: normal completion, no abort.
        set_stub(1'b0, TO - 1, 1'b1, 18'h00ABC, 32'h0BAD_F00D);
        s0 = start_cycles;
        a0 = abort_cycles;
        run_job(4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0);
        chk("tie_start_cycles", start_cycles - s0, TO);
        chk("tie_no_abort", abort_cycles - a0, 0);

        // Reset in the middle of a solve abandons the job.
        set_stub(1'b0, 10, 1'b1, 18'h1, 32'h1);
        req = 4'b0001;
        wait_grant(n);
        chk("rst_run_grant", grant, 4'b0001);
        repeat (3) cyc();
        chk("rst_run_start_before", solver_start, 1);
        reset = 1'b1;
        #1;
        chk("rst_run_start", solver_start, 0);
        chk("rst_run_grant_clr", grant, 0);
        chk("rst_run_valid", resp_valid, 0);
        chk("rst_run_jobs_done", jobs_done, 0);
        req = 4'b0000;
        repeat (2) cyc();
        reset = 1'b0;
        v0 = valid_cycles;
        repeat (40) cyc();
        chk("rst_run_no_resp", valid_cycles - v0, 0);
        chk("rst_run_sb_empty", rd_ptr, sb.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
